// File: rtl/fpcvt_pkg.sv
// Shared widths and FSM state type for the linear-to-float converter.
// Optional rounding is enabled by defining FPCVT_ROUND_EN.
package fpcvt_pkg;
    localparam int IN_W  = 12;
    localparam int MAG_W = 11;
    localparam int EXP_W = 3;
    localparam int SIG_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        HOLD
    } state_e;
endpackage

// File: rtl/fpcvt_round.sv
// Combinational round/saturate of the significand and exponent.
// FPCVT_ROUND_EN selects round-half-up; otherwise plain truncation.
module fpcvt_round
    import fpcvt_pkg::*;
(
    input  logic [SIG_W-1:0] f_i,
    input  logic             r_i,
    input  logic [EXP_W-1:0] e_i,
    output logic [SIG_W-1:0] f_o,
    output logic [EXP_W-1:0] e_o
);
`ifdef FPCVT_ROUND_EN
    logic [SIG_W:0] sum;

    assign sum = {1'b0, f_i} + {{SIG_W{1'b0}}, r_i};

    always_comb begin
        f_o = sum[SIG_W-1:0];
        e_o = e_i;
        // Carry out renormalises to 1000; the top exponent clamps instead.
        if (sum[SIG_W]) begin
            if (&e_i) begin
                f_o = '1;
            end else begin
                f_o = {1'b1, {(SIG_W-1){1'b0}}};
                e_o = e_i + EXP_W'(1);
            end
        end
    end
`else
    logic unused_r;

    assign unused_r = r_i;
    assign f_o      = f_i;
    assign e_o      = e_i;
`endif
endmodule

// File: rtl/convert_ctrl.sv
// Sequential 12-bit two's-complement to sign/E/F float converter.
// Rounding in ROUND is enabled by defining FPCVT_ROUND_EN.
module convert_ctrl
    import fpcvt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [EXP_W-1:0] exponent,
    output logic [SIG_W-1:0] significand,
    output logic             busy
);
    state_e             state_q, state_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [EXP_W-1:0]   e_q, e_d;
    logic               sgn_q, sgn_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [MAG_W-1:0]   abs_w;
    logic [SIG_W-1:0]   f_rnd;
    logic [EXP_W-1:0]   e_rnd;

    // -2048 has no 11-bit magnitude, so it clamps to 2047.
    always_comb begin
        abs_w = in_data[MAG_W-1:0];
        if (in_data[IN_W-1]) begin
            if (in_data[MAG_W-1:0] == '0) begin
                abs_w = '1;
            end else begin
                abs_w = ~in_data[MAG_W-1:0] + MAG_W'(1);
            end
        end
    end

    fpcvt_round u_round (
        .f_i (mag_q[MAG_W-1 -: SIG_W]),
        .r_i (mag_q[MAG_W-1-SIG_W]),
        .e_i (e_q),
        .f_o (f_rnd),
        .e_o (e_rnd)
    );

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        e_d     = e_q;
        sgn_d   = sgn_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sgn_d   = in_data[IN_W-1];
                    mag_d   = abs_w;
                    e_d     = '1;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q[MAG_W-1] || e_q == '0) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[MAG_W-2:0], 1'b0};
                    e_d   = e_q - EXP_W'(1);
                end
            end
            ROUND: begin
                sign_d  = sgn_q;
                exp_d   = e_rnd;
                sig_d   = f_rnd;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_q   <= '0;
            e_q     <= '0;
            sgn_q   <= 1'b0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            e_q     <= e_d;
            sgn_q   <= sgn_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            sig_q   <= sig_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign sign        = sign_q;
    assign exponent    = exp_q;
    assign significand = sig_q;
endmodule

// File: tb/tb_convert_ctrl.sv
// Randomised and directed bench for convert_ctrl against an arithmetic model.
// Model rounding follows FPCVT_ROUND_EN like the design build.
module tb_convert_ctrl;
    logic        clk;
    logic        rst_n;
    logic [11:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [2:0]  exponent;
    logic [3:0]  significand;
    logic        busy;

    int vectors;
    int errors;

    convert_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sign        (sign),
        .exponent    (exponent),
        .significand (significand),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Value = F * 2^E, found by doubling the magnitude until bit 10 or E=0.
    task automatic model(input logic [11:0] d, output int s, output int e,
                         output int f, output int lat);
        int v, m, sh, r;
        v = int'($signed(d));
        s = (v < 0) ? 1 : 0;
        m = (v < 0) ? -v : v;
        if (m > 2047) m = 2047;
        sh = 0;
        while (sh < 7 && m < 1024) begin
            m = m * 2;
            sh++;
        end
        e = 7 - sh;
        f = m / 128;
        r = (m / 64) % 2;
        lat = sh + 2;
`ifdef FPCVT_ROUND_EN
        if (r == 1) begin
            f++;
            if (f == 16) begin
                if (e == 7) f = 15;
                else begin
                    f = 8;
                    e++;
                end
            end
        end
`endif
    endtask

    task automatic check_out(input string tag, input int s, input int e, input int f);
        check({tag, ".sign"}, int'(sign), s);
        check({tag, ".exp"}, int'(exponent), e);
        check({tag, ".sig"}, int'(significand), f);
    endtask

    task automatic convert(input logic [11:0] d, input int hold);
        int s, e, f, lat, edges;
        model(d, s, e, f, lat);
        @(negedge clk);
        check("in_ready_idle", int'(in_ready), 1);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        edges = 0;
        forever begin
            @(negedge clk);
            if (out_valid || edges > 20) break;
            check("busy_norm", int'(busy), 1);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 12'($urandom);
            @(posedge clk);
            edges++;
        end
        check("latency", edges, lat);
        if (!out_valid) begin
            in_valid = 1'b0;
            return;
        end
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            check("out_valid_hold", int'(out_valid), 1);
            check("in_ready_hold", int'(in_ready), 0);
            check_out("hold", s, e, f);
            if (i == hold) begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 12'($urandom);
            end
            @(posedge clk);
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after", int'(out_valid), 0);
        check("in_ready_after", int'(in_ready), 1);
        check_out("kept", s, e, f);
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #3;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check_out("rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(12'h000, 0);
        convert(12'd422, 1);
        convert(12'd63, 0);
        convert(12'h800, 2);
        convert(12'hFFF, 0);
        convert(12'd1234, 5);
        for (int i = 0; i < 40; i++) begin
            convert(12'($urandom), int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        in_data  = 12'h000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check_out("mid_rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_rst_quiet", int'(out_valid | busy), 0);
        end
        convert(12'd63, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/convert_ctrl.md
CONVERT_CTRL -- requirements
Module: convert_ctrl

Interface
REQ-001 Parameters: none; all widths SHALL come from fpcvt_pkg (IN_W=12, MAG_W=11, EXP_W=3, SIG_W=4).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_data  in  12  two's-complement linear sample.
REQ-005 in_valid  in  1  in_data valid.
REQ-006 in_ready  out  1  controller can accept; high only in IDLE.
REQ-007 out_valid  out  1  result valid; high only in HOLD.
REQ-008 out_ready  in  1  consumer accepts result.
REQ-009 sign  out  1  result sign.
REQ-010 exponent  out  3  result exponent E.
REQ-011 significand  out  4  result significand F; value = F * 2^E.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, NORM, ROUND, HOLD.
REQ-014 IDLE: on in_valid&&in_ready, capture sign=in_data[11], mag=|in_data| (11 bits), e=7; go NORM.
REQ-015 in_data=-2048 SHALL saturate to mag=2047, sign=1.
REQ-016 NORM, per cycle: if mag[10]==1 or e==0, go ROUND; else mag<<=1, e-=1, stay.
REQ-017 ROUND: F=mag[10:7], r=mag[6]; register results; go HOLD.
REQ-018 With rounding: if r and F==15, F=8 and e+=1; if e was 7, saturate to E=7, F=15.
REQ-019 HOLD: out_valid=1; sign/exponent/significand SHALL stay stable until out_valid&&out_ready, then go IDLE.
REQ-020 With s shifts (0..7), out_valid SHALL rise s+2 cycles after the accept edge (range 2..9).
REQ-021 No new sample SHALL be accepted in NORM, ROUND or HOLD; in_valid there SHALL be ignored.
REQ-022 After a handshake, the next accept SHALL be possible one cycle later, from IDLE.
REQ-023 in_data=0 SHALL yield S=0, E=0, F=0.
REQ-024 Output registers SHALL hold the last result after leaving HOLD, until the next ROUND.

Reset
REQ-025 While rst_n=0: state=IDLE; sign, exponent, significand, out_valid, busy =0; in_ready=1.
REQ-026 Reset asserted in any state SHALL abort the conversion with no partial result and no out_valid pulse.

Configuration
REQ-027 FPCVT_ROUND_EN defined: ROUND SHALL apply REQ-018.
REQ-028 FPCVT_ROUND_EN undefined: ROUND SHALL truncate (F=mag[10:7], E=e); r unused; latency unchanged.

Structure
REQ-029 fpcvt_pkg SHALL hold the width constants and the state enum typedef.
REQ-030 Rounding/saturation SHALL be a combinational sub-module, fpcvt_round (in: F, r, e; out: F', E'), instantiated in ROUND.

Verification
REQ-031 in_data=0x000 -> S=0, E=0, F=0; out_valid 9 cycles after accept.
REQ-032 in_data=422 -> S=0, E=5, F=13; out_valid 4 cycles after accept.
REQ-033 in_data=63 -> with FPCVT_ROUND_EN: E=3, F=8; without: E=2, F=15.
REQ-034 in_data=-2048 -> S=1, E=7, F=15, latency 2; in_data=-1 -> S=1, E=0, F=1.
REQ-035 out_ready low 5 cycles in HOLD -> outputs stable, in_ready=0, in_valid pulses ignored; handshake on 6th -> IDLE next cycle.
REQ-036 rst_n low mid-NORM -> all outputs 0, in_ready=1; no out_valid until a new accept.
